// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared constants for the partial-sum accumulation / activation path.
//   - Q-format widths (signed Q24.8 words, 40-bit accumulators)
//   - FSM state encoding of the row accumulator
//   - ReLU / saturation limits used by the activator
// No ports; imported with "import acc_pkg::*;".
// -----------------------------------------------------------------------------
package acc_pkg;

   // Q-format of the partial sums and of the activated outputs
   localparam int Q_DW = 32;
   localparam int Q_IW = 24;
   localparam int Q_FW = 8;
   // Accumulator width: 32-bit words plus 8 guard bits covers 64 channels
   localparam int Q_AW = 40;

   // Row accumulator FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   // Activation limits: negative results clamp to SAT_MIN, large ones to SAT_MAX
   localparam logic [Q_DW-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [Q_DW-1:0] SAT_MIN = 32'h0000_0000;

endpackage : acc_pkg

// File: rtl/relu_sat.sv
// -----------------------------------------------------------------------------
// relu_sat
// Combinational ReLU plus positive saturation of one accumulated column.
// Ports:
//   din  : AW-bit signed accumulator value (already includes bias)
//   dout : (IW+FW)-bit activated result; 0 for negative input, SAT_MAX when
//          the value does not fit in the signed output word
// -----------------------------------------------------------------------------
module relu_sat
   import acc_pkg::*;
#(
   parameter int AW = Q_AW,
   parameter int IW = Q_IW,
   parameter int FW = Q_FW
) (
   input  logic [AW-1:0]    din,
   output logic [IW+FW-1:0] dout
);

   localparam int QW = IW + FW;
   // Largest positive output value, zero-extended to accumulator width
   localparam logic [AW-1:0] LIMIT = AW'(SAT_MAX);

   // ReLU first (sign bit), then clamp anything above the output range
   always_comb begin
      if (din[AW-1]) begin
         dout = QW'(SAT_MIN);
      end else if (din > LIMIT) begin
         dout = QW'(SAT_MAX);
      end else begin
         dout = din[QW-1:0];
      end
   end

endmodule : relu_sat

// File: rtl/psum_accum_relu.sv
// -----------------------------------------------------------------------------
// psum_accum_relu
// Accumulates CH_IN beats of a COLS-wide row of partial sums, adds the
// output-channel bias, applies ReLU + saturation and serializes the row.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   psum_i      : COLS*DW row of partial sums, column 0 in the LSBs
//   psum_valid  : beat valid        psum_ready : beat accepted (IDLE/ACCUM)
//   bias_i      : bias, sampled on the first beat of each row only
//   data_o      : activated word    out_valid  : data_o valid
//   out_ready   : downstream accept row_done   : pulse after last word taken
// -----------------------------------------------------------------------------
module psum_accum_relu
   import acc_pkg::*;
#(
   parameter int DW    = Q_DW,
   parameter int IW    = Q_IW,
   parameter int FW    = Q_FW,
   parameter int COLS  = 56,
   parameter int CH_IN = 64,
   parameter int AW    = Q_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COLS*DW-1:0] psum_i,
   input  logic               psum_valid,
   output logic               psum_ready,
   input  logic [DW-1:0]      bias_i,
   output logic [DW-1:0]      data_o,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               row_done
);

   localparam int CW = $clog2(CH_IN + 1);
   localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [1:0]    state_r;
   logic [1:0]    state_nx_s;
   logic [CW-1:0] ch_cnt_r;
   logic [CW-1:0] cnt_nx_s;
   logic [XW-1:0] idx_r;
   logic [XW-1:0] idx_nx_s;
   logic [DW-1:0] bias_r;
   logic [DW-1:0] data_r;
   logic          psum_ready_r;
   logic          out_valid_r;
   logic          row_done_r;

   logic [AW-1:0] acc_r [COLS];
   logic [DW-1:0] buf_r [COLS];
   logic [AW-1:0] sum_s [COLS];
   logic [DW-1:0] res_s [COLS];

   logic beat_s;
   logic final_beat_s;
   logic take_s;
   logic last_word_s;

   assign beat_s       = psum_valid & psum_ready_r;
   assign cnt_nx_s     = ch_cnt_r + CW'(1);
   // ch_cnt is 0 in IDLE, so this also covers CH_IN = 1 on the first beat
   assign final_beat_s = beat_s & (cnt_nx_s == CW'(CH_IN));
   assign take_s       = out_valid_r & out_ready;
   assign idx_nx_s     = idx_r + XW'(1);
   assign last_word_s  = take_s & (idx_r == XW'(COLS - 1));

   // Row sequencing: collect beats, one finalize cycle, then drain the buffer
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (final_beat_s) begin
               state_nx_s = ST_FINAL;
            end else if (beat_s) begin
               state_nx_s = ST_ACCUM;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (final_beat_s) begin
               state_nx_s = ST_FINAL;
            end else begin
               state_nx_s = ST_ACCUM;
            end
         end
         ST_FINAL: begin
            state_nx_s = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (last_word_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Bias add (wraps modulo 2^AW) and per-column activation
   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign sum_s[c] = acc_r[c] + {{(AW-DW){bias_r[DW-1]}}, bias_r};

      relu_sat #(
         .AW (AW),
         .IW (IW),
         .FW (FW)
      ) u_relu_sat (
         .din  (sum_s[c]),
         .dout (res_s[c])
      );
   end

   // Control state and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         ch_cnt_r     <= {CW{1'b0}};
         idx_r        <= {XW{1'b0}};
         psum_ready_r <= 1'b1;
         out_valid_r  <= 1'b0;
         row_done_r   <= 1'b0;
         data_r       <= {DW{1'b0}};
      end else begin
         state_r      <= state_nx_s;
         psum_ready_r <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_ACCUM);
         out_valid_r  <= (state_nx_s == ST_DRAIN);
         row_done_r   <= last_word_s;

         if (beat_s) begin
            ch_cnt_r <= cnt_nx_s;
         end else if (last_word_s) begin
            ch_cnt_r <= {CW{1'b0}};
         end

         if (state_r == ST_FINAL) begin
            idx_r <= {XW{1'b0}};
         end else if (last_word_s) begin
            idx_r <= {XW{1'b0}};
         end else if (take_s) begin
            idx_r <= idx_nx_s;
         end

         // data_o is pre-loaded so it always shows buf[idx] while draining
         if (state_r == ST_FINAL) begin
            data_r <= res_s[0];
         end else if (last_word_s) begin
            data_r <= {DW{1'b0}};
         end else if (take_s) begin
            data_r <= buf_r[idx_nx_s];
         end
      end
   end

   // Datapath storage; contents are always written before being observed
   always_ff @(posedge clk) begin
      if (beat_s) begin
         for (int c = 0; c < COLS; c++) begin
            acc_r[c] <= ((state_r == ST_IDLE) ? {AW{1'b0}} : acc_r[c])
                        + {{(AW-DW){psum_i[c*DW + DW - 1]}}, psum_i[c*DW +: DW]};
         end
      end
      if (beat_s && (state_r == ST_IDLE)) begin
         bias_r <= bias_i;
      end
      if (state_r == ST_FINAL) begin
         for (int c = 0; c < COLS; c++) begin
            buf_r[c] <= res_s[c];
         end
      end
   end

   assign psum_ready = psum_ready_r;
   assign out_valid  = out_valid_r;
   assign row_done   = row_done_r;
   assign data_o     = data_r;

endmodule : psum_accum_relu

// File: tb/tb_psum_accum_relu.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_relu
// Scoreboard bench: expected words are queued when a row is driven and popped
// as the DUT drains them.
// -----------------------------------------------------------------------------
module tb_psum_accum_relu;

   localparam int DW    = 32;
   localparam int COLS  = 56;
   localparam int CH_IN = 64;
   localparam int PW    = COLS * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] psum_i = '0;
   logic          psum_valid = 1'b0;
   logic          psum_ready;
   logic [DW-1:0] bias_i = 32'h0;
   logic [DW-1:0] data_o;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          row_done;

   int n_cmp = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   psum_accum_relu #(
      .DW (32), .IW (24), .FW (8), .COLS (COLS), .CH_IN (CH_IN), .AW (40)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .psum_i     (psum_i),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .bias_i     (bias_i),
      .data_o     (data_o),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .row_done   (row_done)
   );

   // Reference: constant per-beat value summed over beats, bias, ReLU, saturate
   function automatic logic [DW-1:0] model_word(input logic [DW-1:0] v, input int beats,
                                                input logic [DW-1:0] b);
      longint s;
      s = longint'($signed(v)) * beats + longint'($signed(b));
      if (s < 0) return 32'h0;
      else if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      else return s[31:0];
   endfunction

   task automatic expect_row(input logic [PW-1:0] pat, input int beats, input logic [DW-1:0] b);
      for (int c = 0; c < COLS; c++) exp_q.push_back(model_word(pat[c*DW +: DW], beats, b));
   endtask

   // Offer beats until n are accepted; bias switches to b_later after the first
   task automatic send_beats(input int n, input logic [PW-1:0] pat, input logic [DW-1:0] b_first,
                             input logic [DW-1:0] b_later, input bit hold);
      int sent = 0;
      int guard = 0;
      logic rdy;
      psum_i = pat; bias_i = b_first; psum_valid = 1'b1;
      while (sent < n && guard < 4 * n + 200) begin
         rdy = psum_ready;
         @(posedge clk); #1;
         guard++;
         if (rdy) begin
            sent++;
            bias_i = b_later;
         end
      end
      if (!hold) psum_valid = 1'b0;
      n_cmp++;
      if (sent != n) begin
         n_err++;
         $display("FAIL beats_accepted: got %0d required %0d", sent, n);
      end
   endtask

   // Pop/compare every drained word; optional random back-pressure
   task automatic drain_row(input int stall_pct);
      int got = 0;
      int guard = 0;
      logic stalled = 1'b0;
      logic [DW-1:0] held = '0;
      logic [DW-1:0] exp_w;
      while (got < COLS && guard < 2000) begin
         if (stalled) begin
            n_cmp++;
            if (out_valid !== 1'b1 || data_o !== held) begin
               n_err++;
               $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", out_valid, data_o, held);
            end
         end
         out_ready = ($urandom_range(99) >= stall_pct);
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (psum_ready !== 1'b0) begin
               n_err++;
               $display("FAIL ready_in_drain: psum_ready=%b required 0", psum_ready);
            end
            if (out_ready) begin
               exp_w = exp_q.pop_front();
               n_cmp++;
               if (data_o !== exp_w) begin
                  n_err++;
                  $display("FAIL data_col%0d: got %h required %h", got, data_o, exp_w);
               end
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = data_o;
            end
         end else begin
            stalled = 1'b0;
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b1;
      n_cmp++;
      if (got != COLS) begin
         n_err++;
         $display("FAIL drain_count: got %0d words required %0d", got, COLS);
      end
      n_cmp++;
      if (row_done !== 1'b1) begin
         n_err++;
         $display("FAIL row_done_pulse: got %b required 1", row_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || row_done !== 1'b0 || data_o !== 32'h0 || psum_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: valid=%b done=%b data=%h ready=%b required 0 0 0 1",
                  out_valid, row_done, data_o, psum_ready);
      end
   endtask

   task automatic test_basic();
      logic [PW-1:0] pat;
      for (int c = 0; c < COLS; c++) pat[c*DW +: DW] = 32'h0000_0100;
      expect_row(pat, CH_IN, 32'h80);
      send_beats(CH_IN, pat, 32'h80, 32'h80, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0 || psum_ready !== 1'b0) begin
         n_err++;
         $display("FAIL latency_final: valid=%b ready=%b required 0 0", out_valid, psum_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL latency_first_valid: valid=%b required 1", out_valid);
      end
      drain_row(0);
      @(posedge clk); #1;
      n_cmp++;
      if (row_done !== 1'b0 || psum_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL after_row: done=%b ready=%b valid=%b required 0 1 0", row_done, psum_ready, out_valid);
      end
   endtask

   task automatic test_relu();
      logic [PW-1:0] pat;
      for (int c = 0; c < COLS; c++) pat[c*DW +: DW] = 32'(-(c * 256));
      expect_row(pat, CH_IN, 32'h0);
      send_beats(CH_IN, pat, 32'h0, 32'h0, 1'b0);
      drain_row(0);
   endtask

   task automatic test_saturation();
      logic [PW-1:0] pat;
      for (int c = 0; c < COLS; c++) pat[c*DW +: DW] = 32'h7FFF_FFFF;
      expect_row(pat, CH_IN, 32'h0);
      send_beats(CH_IN, pat, 32'h0, 32'h0, 1'b0);
      drain_row(0);
   endtask

   task automatic test_stall();
      logic [PW-1:0] pat;
      for (int c = 0; c < COLS; c++) pat[c*DW +: DW] = 32'((c + 1) * 16);
      expect_row(pat, CH_IN, 32'h5);
      send_beats(CH_IN, pat, 32'h5, 32'h5, 1'b0);
      drain_row(50);
   endtask

   task automatic test_reset_midrow();
      logic [PW-1:0] pat;
      for (int c = 0; c < COLS; c++) pat[c*DW +: DW] = 32'h0000_0100;
      send_beats(30, pat, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_valid !== 1'b0 || psum_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrow_reset_idle: valid=%b ready=%b required 0 1", out_valid, psum_ready);
         end
         @(posedge clk); #1;
      end
      expect_row(pat, CH_IN, 32'h0);
      send_beats(CH_IN, pat, 32'h0, 32'h0, 1'b0);
      drain_row(0);
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0] pat1;
      logic [PW-1:0] pat2;
      for (int c = 0; c < COLS; c++) begin
         pat1[c*DW +: DW] = 32'((c + 1) * 256);
         pat2[c*DW +: DW] = 32'h0000_0200;
      end
      expect_row(pat1, CH_IN, 32'h100);
      send_beats(CH_IN, pat1, 32'h100, 32'hFFFF_0000, 1'b1);
      drain_row(0);
      n_cmp++;
      if (psum_ready !== 1'b1 || psum_valid !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_accept_window: ready=%b valid=%b required 1 1", psum_ready, psum_valid);
      end
      expect_row(pat2, CH_IN, 32'h0);
      send_beats(CH_IN, pat2, 32'h0, 32'h0, 1'b0);
      drain_row(0);
   endtask

   // Hard stop if something hangs beyond every per-task bound
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_saturation();
      test_stall();
      test_reset_midrow();
      test_back_to_back();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_empty: %0d words left required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_psum_accum_relu

// File: doc/psum_accum_relu.md
PSUM_ACCUM_RELU -- requirements
Module: psum_accum_relu

Interface
REQ-001 SHALL have parameter DW, default 32, meaning output/partial-sum word width (signed Q24.8).
REQ-002 SHALL have parameter IW, default 24, meaning integer bits of the Q format.
REQ-003 SHALL have parameter FW, default 8, meaning fraction bits of the Q format.
REQ-004 SHALL have parameter COLS, default 56, meaning columns per feature-map row.
REQ-005 SHALL have parameter CH_IN, default 64, meaning input channels accumulated per output row.
REQ-006 SHALL have parameter AW, default 40, meaning signed accumulator width.
REQ-007 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port psum_i  input  COLS*DW  one row of PE-array partial sums, column 0 in the LSBs.
REQ-010 SHALL have port psum_valid  input  1  psum_i beat valid.
REQ-011 SHALL have port psum_ready  output  1  block accepts a beat.
REQ-012 SHALL have port bias_i  input  DW  output-channel bias, Q24.8.
REQ-013 SHALL have port data_o  output  DW  serialized activated result.
REQ-014 SHALL have port out_valid  output  1  data_o valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts data_o.
REQ-016 SHALL have port row_done  output  1  one-cycle pulse after the last word of a row is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, FINAL, DRAIN.
REQ-018 A beat SHALL transfer when psum_valid and psum_ready are both 1; psum_ready SHALL be 1 in IDLE and ACCUM only.
REQ-019 The first beat of a row (ch_cnt = 0, accepted in IDLE) SHALL load each accumulator with sign-extended psum, capture bias_i, set ch_cnt = 1 and move to ACCUM.
REQ-020 In ACCUM, each beat SHALL add sign-extended psum per column and increment ch_cnt; the beat making ch_cnt = CH_IN SHALL move to FINAL.
REQ-021 With CH_IN = 1, the first beat SHALL move directly to FINAL.
REQ-022 FINAL SHALL last exactly one cycle and compute per column r = acc + sext(bias), then ReLU (r < 0 gives 0), then saturation (r > 2^(DW-1)-1 gives 0x7FFFFFFF); it SHALL store results in an output buffer, set idx = 0 and move to DRAIN.
REQ-023 Accumulation SHALL wrap modulo 2^AW with no overflow detection; AW = 40 is guaranteed sufficient for CH_IN <= 64 and DW = 32.
REQ-024 In DRAIN, out_valid SHALL be 1 and data_o SHALL equal buf[idx]; on out_ready, idx SHALL increment.
REQ-025 While out_valid = 1 and out_ready = 0, data_o SHALL hold stable.
REQ-026 Acceptance of idx = COLS-1 SHALL assert row_done for the next cycle and return the FSM to IDLE, clearing ch_cnt.
REQ-027 Latency SHALL be as follows: last psum beat accepted at cycle t, FINAL at t+1, first out_valid at t+2; minimum row drain is COLS cycles.
REQ-028 psum_valid asserted outside IDLE/ACCUM SHALL be ignored (psum_ready = 0); no beat SHALL be lost or double-counted.
REQ-029 bias_i SHALL be sampled only on the first beat of a row; later changes SHALL have no effect on that row.

Reset
REQ-030 On rst = 1, the FSM SHALL go to IDLE, ch_cnt = 0, idx = 0, out_valid = 0, row_done = 0, data_o = 0 and psum_ready = 1 from the following cycle.
REQ-031 Reset mid-row (ACCUM or DRAIN) SHALL discard the partial row; the next accepted beat SHALL be treated as ch_cnt = 0.
REQ-032 Accumulator and buffer contents need not be reset; they SHALL be unobservable before being written.

Structure
REQ-033 The Q-format constants (DW, IW, FW, AW), the FSM state encoding and the saturation limits SHALL live in a shared package/header (acc_pkg) reused by the PE and activator blocks.
REQ-034 One sub-module, relu_sat (AW-bit in, DW-bit out, combinational ReLU plus saturation), SHALL be instantiated COLS times via generate.

Verification
REQ-035 CH_IN = 64 beats, all columns = 0x00000100 (1.0), bias = 0x00000080 (0.5) -> every data_o = 0x00004080, 56 words, then row_done pulse.
REQ-036 Column k psum = -k*0x100 on every beat, bias = 0 -> data_o[0] = 0, all other columns = 0 (ReLU).
REQ-037 All columns = 0x7FFFFFFF for 64 beats -> every data_o = 0x7FFFFFFF (saturation).
REQ-038 out_ready toggled randomly during DRAIN -> data_o stable while stalled, column order 0..55 preserved, psum_ready = 0 throughout.
REQ-039 rst pulsed after 30 beats -> no out_valid; the following 64 beats of value 0x100, bias 0 -> data_o = 0x4000 (no residue from the aborted row).
REQ-040 Back-to-back rows with psum_valid held high -> first beat of row 2 accepted in the cycle after row_done; bias change mid-row ignored.
